qpi_bus_arbiter: RTL and testbench
==================================

QPI_BUS_ARBITER -- requirements
Module: qpi_bus_arbiter

Shares one 4-bit QPI pad group (io0..io3 plus SCLK) between master 0 (flash XIP controller) and master 1 (ML accelerator host port). Each master has its own chip select.

Interface
REQ-001 Parameter TURN_CYCLES, default 2: idle cycles with the bus undriven between any two grants; legal range 1..15.
REQ-002 Parameter HOLD_LIMIT, default 1024: number of held cycles after which yield is asserted to the holder; 16-bit range.
REQ-003 clk  in  1: single clock; all state changes on its rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 mN_req  in  1 (N=0,1): master requests the bus; held high for the whole ownership period.
REQ-006 mN_gnt  out  1: registered grant.
REQ-007 mN_csb  in  1: master chip select, active low.
REQ-008 mN_sclk  in  1: master serial clock.
REQ-009 mN_io_oe  in  4: master per-bit output enables.
REQ-010 mN_io_do  in  4: master output data.
REQ-011 mN_io_di  out  4: input data returned to the master.
REQ-012 mN_yield  out  1: request for the holder to release the bus soon.
REQ-013 pad_csb0 / pad_csb1  out  1 each: flash chip select and accelerator chip select.
REQ-014 pad_sclk  out  1: shared serial clock pad.
REQ-015 pad_io_oe  out  4: pad output enables.
REQ-016 pad_io_do  out  4: pad output data.
REQ-017 pad_io_di  in  4: pad input data.
REQ-018 busy  out  1: high in every state except IDLE.

Function
REQ-019 States: IDLE, GNT0, GNT1, TURN. The state register and a last-served pointer (LAST) are the only arbitration state.
REQ-020 IDLE, any req high: next state GNTn. If both are high, grant the master other than LAST.
REQ-021 mN_gnt SHALL be high exactly when the state is GNTN. The grant is visible one cycle after req is first sampled high in IDLE.
REQ-022 Pad muxing in GNTN, combinational from the registered state:
  - pad_csbN = mN_csb
  - pad_sclk = mN_sclk
  - pad_io_oe = mN_io_oe
  - pad_io_do = mN_io_do
  - mN_io_di = pad_io_di
REQ-023 Non-holder and all non-GNT states:
  - both pad_csb = 1
  - pad_sclk = 0
  - pad_io_oe = 0
  - pad_io_do = 0
  - mN_io_di = 0 for the non-holder
REQ-024 Release from GNTN occurs only when mN_req=0 and mN_csb=1 in the same cycle. It updates LAST=N and moves to TURN.
REQ-025 mN_req dropped while mN_csb=0: stay in GNTN and keep muxing until csb rises, so a transaction is never truncated.
REQ-026 TURN lasts exactly TURN_CYCLES cycles (down-counter). It then goes to IDLE, and the REQ-020 rule applies on the following cycle.
REQ-027 Hold counter: cleared on entry to GNTN, increments each GNT cycle, saturates at 0xFFFF.
REQ-028 mN_yield = 1 when state is GNTN, hold count >= HOLD_LIMIT and the other req is high. It falls with the grant and never forces release.
REQ-029 Requests arriving during GNT or TURN wait. No request is lost as long as req stays high.
REQ-030 Worst-case wait for a requester: the holder's tenure plus TURN_CYCLES + 2 cycles.

Reset
REQ-031 While reset is high at a clock edge, the next state SHALL be:
  - state IDLE, LAST=1 (so master 0 wins the first tie), counters 0
  - gnt 0, yield 0, busy 0
  - pad_csb0 = pad_csb1 = 1, pad_sclk 0, pad_io_oe 0
REQ-032 Reset during GNT mid-transfer SHALL deassert the granted chip select at the next edge. No TURN is inserted after reset.

Verification
REQ-033 Reset, then m0_req=1 at cycle 0 → m0_gnt=1 at cycle 1; pad_csb0 tracks m0_csb; pad_csb1 stays 1.
REQ-034 Both req rise together after reset → m0 granted. m0 releases → TURN held 2 cycles (oe=0, both csb=1) → m1_gnt 1 cycle later.
REQ-035 m1_req held, m0 drops req with m0_csb=0 for 5 cycles → grant kept until m0_csb=1, then TURN.
REQ-036 HOLD_LIMIT=8, m0 holds with m1_req=1 → m0_yield rises after 8 GNT cycles and falls when the grant ends.
REQ-037 Reset asserted in GNT1 with pad_io_oe=4'hF → next cycle: pad_io_oe=0, pad_csb1=1, m1_gnt=0, state IDLE.
REQ-038 Both masters requesting continuously for 10 tenures → grants strictly alternate 0,1,0,1… and no cycle has both gnt high.

Source files
------------

// File: rtl/qpi_bus_arbiter_if.sv
// Signal bundle between the QPI bus arbiter, its two masters and the shared pad group.
// The slave modport is the arbiter's view; the master modport is the masters/pad side.
interface qpi_bus_arbiter_if;
  logic       m0_req,   m1_req;
  logic       m0_gnt,   m1_gnt;
  logic       m0_csb,   m1_csb;
  logic       m0_sclk,  m1_sclk;
  logic [3:0] m0_io_oe, m1_io_oe;
  logic [3:0] m0_io_do, m1_io_do;
  logic [3:0] m0_io_di, m1_io_di;
  logic       m0_yield, m1_yield;
  logic       pad_csb0, pad_csb1;
  logic       pad_sclk;
  logic [3:0] pad_io_oe;
  logic [3:0] pad_io_do;
  logic [3:0] pad_io_di;
  logic       busy;

  modport slave (
    input  m0_req, m1_req, m0_csb, m1_csb, m0_sclk, m1_sclk,
    input  m0_io_oe, m1_io_oe, m0_io_do, m1_io_do, pad_io_di,
    output m0_gnt, m1_gnt, m0_io_di, m1_io_di, m0_yield, m1_yield,
    output pad_csb0, pad_csb1, pad_sclk, pad_io_oe, pad_io_do, busy
  );

  modport master (
    output m0_req, m1_req, m0_csb, m1_csb, m0_sclk, m1_sclk,
    output m0_io_oe, m1_io_oe, m0_io_do, m1_io_do, pad_io_di,
    input  m0_gnt, m1_gnt, m0_io_di, m1_io_di, m0_yield, m1_yield,
    input  pad_csb0, pad_csb1, pad_sclk, pad_io_oe, pad_io_do, busy
  );
endinterface

// File: rtl/qpi_bus_arbiter.sv
// Two-master arbiter for a shared 4-bit QPI pad group: alternating priority on ties,
// transaction-safe release (waits for csb high) and an enforced undriven turnaround gap.
module qpi_bus_arbiter #(
  parameter int unsigned TURN_CYCLES = 2,
  parameter int unsigned HOLD_LIMIT  = 1024
) (
  input logic              clk,
  input logic              reset,
  qpi_bus_arbiter_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StGnt0 = 2'd1;
  localparam logic [1:0] StGnt1 = 2'd2;
  localparam logic [1:0] StTurn = 2'd3;

  // Counter is loaded with TURN_CYCLES-1 so the TURN state spans exactly TURN_CYCLES cycles.
  localparam logic [3:0]  TurnLoad  = 4'(TURN_CYCLES - 1);
  localparam logic [15:0] HoldLimit = 16'(HOLD_LIMIT);

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  turn_q, turn_d;
  logic [15:0] hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    turn_d  = turn_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: begin
        // On a tie, the master that was not served last wins.
        if (bus.m0_req && (!bus.m1_req || last_q)) begin
          state_d = StGnt0;
          hold_d  = '0;
        end else if (bus.m1_req) begin
          state_d = StGnt1;
          hold_d  = '0;
        end
      end
      StGnt0: begin
        if (!bus.m0_req && bus.m0_csb) begin
          state_d = StTurn;
          last_d  = 1'b0;
          turn_d  = TurnLoad;
        end else if (hold_q != 16'hFFFF) begin
          hold_d = hold_q + 16'd1;
        end
      end
      StGnt1: begin
        if (!bus.m1_req && bus.m1_csb) begin
          state_d = StTurn;
          last_d  = 1'b1;
          turn_d  = TurnLoad;
        end else if (hold_q != 16'hFFFF) begin
          hold_d = hold_q + 16'd1;
        end
      end
      default: begin
        if (turn_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          turn_d = turn_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      turn_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      turn_q  <= turn_d;
      hold_q  <= hold_d;
    end
  end

  logic gnt0, gnt1;
  assign gnt0 = (state_q == StGnt0);
  assign gnt1 = (state_q == StGnt1);

  always_comb begin
    bus.m0_gnt    = gnt0;
    bus.m1_gnt    = gnt1;
    bus.busy      = (state_q != StIdle);
    bus.m0_yield  = gnt0 && (hold_q >= HoldLimit) && bus.m1_req;
    bus.m1_yield  = gnt1 && (hold_q >= HoldLimit) && bus.m0_req;
    bus.pad_csb0  = 1'b1;
    bus.pad_csb1  = 1'b1;
    bus.pad_sclk  = 1'b0;
    bus.pad_io_oe = '0;
    bus.pad_io_do = '0;
    bus.m0_io_di  = '0;
    bus.m1_io_di  = '0;
    if (gnt0) begin
      bus.pad_csb0  = bus.m0_csb;
      bus.pad_sclk  = bus.m0_sclk;
      bus.pad_io_oe = bus.m0_io_oe;
      bus.pad_io_do = bus.m0_io_do;
      bus.m0_io_di  = bus.pad_io_di;
    end else if (gnt1) begin
      bus.pad_csb1  = bus.m1_csb;
      bus.pad_sclk  = bus.m1_sclk;
      bus.pad_io_oe = bus.m1_io_oe;
      bus.pad_io_do = bus.m1_io_do;
      bus.m1_io_di  = bus.pad_io_di;
    end
  end

endmodule

// File: tb/tb_qpi_bus_arbiter.sv
// Randomized bench for qpi_bus_arbiter: protocol-following masters, random resets,
// and a cycle-level reference model of ownership, turnaround, fairness and yield.
module tb_qpi_bus_arbiter;

  localparam int unsigned TurnCycles = 2;
  localparam int unsigned HoldLimit  = 8;
  localparam int          NumCycles  = 3000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qpi_bus_arbiter_if bus ();

  qpi_bus_arbiter #(
    .TURN_CYCLES(TurnCycles),
    .HOLD_LIMIT (HoldLimit)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (-1 = nobody), remaining gap cycles, last served, tenure.
  int owner, turn_left, last, hold;
  int max_wait;

  // Master stimulus state.
  logic       r [2];
  logic       c [2];
  logic       sk[2];
  logic [3:0] oe[2];
  logic [3:0] dout[2];
  logic [3:0] di;
  bit         want[2];
  bit         active[2];
  int         tenure[2];
  int         waited[2];

  task automatic drive_bus();
    bus.m0_req   = r[0];    bus.m1_req   = r[1];
    bus.m0_csb   = c[0];    bus.m1_csb   = c[1];
    bus.m0_sclk  = sk[0];   bus.m1_sclk  = sk[1];
    bus.m0_io_oe = oe[0];   bus.m1_io_oe = oe[1];
    bus.m0_io_do = dout[0]; bus.m1_io_do = dout[1];
    bus.pad_io_di = di;
  endtask

  task automatic check_outputs();
    bit g0, g1;
    g0 = (owner == 0);
    g1 = (owner == 1);
    check("m0_gnt", 32'(bus.m0_gnt), 32'(g0));
    check("m1_gnt", 32'(bus.m1_gnt), 32'(g1));
    check("gnt_excl", 32'(bus.m0_gnt & bus.m1_gnt), 32'd0);
    check("busy", 32'(bus.busy), 32'(owner >= 0 || turn_left > 0));
    check("m0_yield", 32'(bus.m0_yield), 32'(g0 && hold >= int'(HoldLimit) && r[1]));
    check("m1_yield", 32'(bus.m1_yield), 32'(g1 && hold >= int'(HoldLimit) && r[0]));
    check("pad_csb0", 32'(bus.pad_csb0), 32'(g0 ? c[0] : 1'b1));
    check("pad_csb1", 32'(bus.pad_csb1), 32'(g1 ? c[1] : 1'b1));
    check("pad_sclk", 32'(bus.pad_sclk), 32'(g0 ? sk[0] : g1 ? sk[1] : 1'b0));
    check("pad_io_oe", 32'(bus.pad_io_oe), 32'(g0 ? oe[0] : g1 ? oe[1] : 4'h0));
    check("pad_io_do", 32'(bus.pad_io_do), 32'(g0 ? dout[0] : g1 ? dout[1] : 4'h0));
    check("m0_io_di", 32'(bus.m0_io_di), 32'(g0 ? di : 4'h0));
    check("m1_io_di", 32'(bus.m1_io_di), 32'(g1 ? di : 4'h0));
  endtask

  task automatic model_step();
    if (reset) begin
      owner = -1; turn_left = 0; last = 1; hold = 0;
    end else if (owner >= 0) begin
      if (!r[owner] && c[owner]) begin
        last = owner; owner = -1; turn_left = int'(TurnCycles);
      end else if (hold < 65535) begin
        hold++;
      end
    end else if (turn_left > 0) begin
      turn_left--;
    end else if (r[0] || r[1]) begin
      owner = (r[0] && r[1]) ? 1 - last : (r[0] ? 0 : 1);
      hold  = 0;
    end
  endtask

  initial begin
    owner = -1; turn_left = 0; last = 1; hold = 0; max_wait = 0;
    for (int n = 0; n < 2; n++) begin
      r[n] = 1'b0; c[n] = 1'b1; sk[n] = 1'b0; oe[n] = '0; dout[n] = '0;
      want[n] = 1'b0; active[n] = 1'b0; tenure[n] = 0; waited[n] = 0;
    end
    di = '0;
    reset = 1'b1;
    drive_bus();
    repeat (2) @(posedge clk);

    for (int cyc = 0; cyc < NumCycles; cyc++) begin
      @(negedge clk);
      reset = (cyc < 2) || ($urandom_range(0, 99) == 0);
      for (int n = 0; n < 2; n++) begin
        if (owner == n) begin
          if (!active[n]) begin
            active[n] = 1'b1;
            tenure[n] = $urandom_range(1, 20);
          end
          if (tenure[n] > 0) begin
            tenure[n]--;
            r[n] = 1'b1;
          end else begin
            r[n]    = 1'b0;
            want[n] = 1'b0;
          end
          // Mostly mid-transaction; csb low delays release after req drops.
          c[n] = ($urandom_range(0, 2) == 0);
        end else begin
          active[n] = 1'b0;
          if (cyc >= 1200 && cyc < 1600) want[n] = 1'b1;
          else if (!want[n]) want[n] = ($urandom_range(0, 3) == 0);
          r[n] = want[n];
          c[n] = 1'b1;
        end
        sk[n]   = 1'($urandom);
        oe[n]   = 4'($urandom);
        dout[n] = 4'($urandom);
      end
      di = 4'($urandom);
      drive_bus();
      #1;
      check_outputs();
      @(posedge clk);
      model_step();
      for (int n = 0; n < 2; n++) begin
        if (r[n] && owner != n && !reset) waited[n]++;
        else waited[n] = 0;
        if (waited[n] > max_wait) max_wait = waited[n];
      end
    end
    // Tenure is at most 20 req cycles plus the csb tail; the wait must stay well bounded.
    check("max_wait_bounded", 32'(max_wait <= 80), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
